booth_pp_gen: RTL



---
 rtl/mul_pkg.sv | 40 ++++
 rtl/booth_pp_row.sv | 35 +++
 rtl/booth_pp_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier definitions: radix-4 Booth digit type, group codes and the
// group-to-digit encoder used by the partial-product generator.
package mul_pkg;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_dig_e;

   // Overlapping 3-bit multiplier groups {b[2i+1], b[2i], b[2i-1]}
   localparam logic [2:0] GRP_ZERO_P = 3'b000;
   localparam logic [2:0] GRP_POS1_A = 3'b001;
   localparam logic [2:0] GRP_POS1_B = 3'b010;
   localparam logic [2:0] GRP_POS2   = 3'b011;
   localparam logic [2:0] GRP_NEG2   = 3'b100;
   localparam logic [2:0] GRP_NEG1_A = 3'b101;
   localparam logic [2:0] GRP_NEG1_B = 3'b110;
   localparam logic [2:0] GRP_ZERO_N = 3'b111;

   function automatic booth_dig_e booth_enc(input logic [2:0] grp);
      booth_dig_e dig;
      dig = ZERO;
      case (grp)
         GRP_ZERO_P: dig = ZERO;
         GRP_POS1_A: dig = POS1;
         GRP_POS1_B: dig = POS1;
         GRP_POS2:   dig = POS2;
         GRP_NEG2:   dig = NEG2;
         GRP_NEG1_A: dig = NEG1;
         GRP_NEG1_B: dig = NEG1;
         GRP_ZERO_N: dig = ZERO;
         default:    dig = ZERO;
      endcase
      return dig;
   endfunction

endpackage

// File: rtl/booth_pp_row.sv
// One Booth partial-product row: digit x a_ext, weighted by 4^RowIdx, modulo 2^ProdDw.
module booth_pp_row
   import mul_pkg::*;
#(
   parameter int unsigned ProdDw = 16,
   parameter int unsigned RowIdx = 0
) (
   input  booth_dig_e        dig_i,
   input  logic [ProdDw-1:0] a_ext_i,
   output logic [ProdDw-1:0] pp_row_c
);

   localparam int unsigned Shift = 2 * RowIdx;

   logic [ProdDw-1:0] a_dbl;
   logic [ProdDw-1:0] mult;

   assign a_dbl = a_ext_i << 1;

   // Negation is a full two's complement so no correction row is needed downstream
   always_comb begin
      mult = '0;
      case (dig_i)
         ZERO:    mult = '0;
         POS1:    mult = a_ext_i;
         POS2:    mult = a_dbl;
         NEG1:    mult = ~a_ext_i + ProdDw'(1);
         NEG2:    mult = ~a_dbl + ProdDw'(1);
         default: mult = '0;
      endcase
   end

   assign pp_row_c = mult << Shift;

endmodule

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator with a single registered stage and
// valid/ready handshake; feeds the compressor tree's addend and pp_opt inputs.
module booth_pp_gen
   import mul_pkg::*;
#(
   parameter int unsigned OpDw   = 8,
   parameter int unsigned ProdDw = 2 * OpDw,
   parameter int unsigned PpNum  = OpDw / 2 + 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic                         signed_i,
   input  logic [OpDw-1:0]              a_i,
   input  logic [OpDw-1:0]              b_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [PpNum-1:0][ProdDw-1:0] pp_o,
   output logic                         pp_opt_o
);

   localparam int unsigned BextDw = OpDw + 3;
   localparam int unsigned ExtDw  = ProdDw - OpDw;

   logic [BextDw-1:0]              b_ext;
   logic [ProdDw-1:0]              a_ext;
   logic                           b_sign;
   logic                           a_sign;
   booth_dig_e                     dig [PpNum];
   logic [PpNum-1:0][ProdDw-1:0]   row_c;
   logic [PpNum-1:0][ProdDw-1:0]   pp_d;
   logic                           accept_c;
   logic                           fire_c;

   assign in_ready_o = !out_valid_o || out_ready_i;
   assign accept_c   = in_valid_i && in_ready_o && !flush_i;
   assign fire_c     = out_valid_o && out_ready_i;

   // Operand extension follows the selected signedness for both operands
   assign b_sign = signed_i & b_i[OpDw-1];
   assign a_sign = signed_i & a_i[OpDw-1];
   assign b_ext  = {b_sign, b_sign, b_i, 1'b0};
   assign a_ext  = {{ExtDw{a_sign}}, a_i};

   for (genvar gi = 0; gi < PpNum; gi++) begin : g_row
      assign dig[gi] = booth_enc(b_ext[2*gi +: 3]);

      booth_pp_row #(
         .ProdDw (ProdDw),
         .RowIdx (gi)
      ) u_row (
         .dig_i    (dig[gi]),
         .a_ext_i  (a_ext),
         .pp_row_c (row_c[gi])
      );
   end

   // Signed recoding only needs PpNum-1 rows; the top row is zeroed so the tree can skip it
   always_comb begin
      pp_d = row_c;
      if (signed_i) begin
         pp_d[PpNum-1] = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
      end else if (flush_i) begin
         out_valid_o <= 1'b0;
      end else if (accept_c) begin
         out_valid_o <= 1'b1;
      end else if (fire_c) begin
         out_valid_o <= 1'b0;
      end
   end

   // Data registers load only on accept so they stay quiet while idle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pp_o     <= '0;
         pp_opt_o <= 1'b0;
      end else if (accept_c) begin
         pp_o     <= pp_d;
         pp_opt_o <= signed_i;
      end
   end

endmodule
